ddr2dbuf_stream: RTL and testbench
==================================

// Module: ddr2dbuf_stream
// PURPOSE
//  Parametrised DDR-to-data-buffer loader with valid/ready backpressure: accepts one DDR word per
//  handshake and turns the stream into banked write strobes for the PE array's dbufs.
//  CONV mode: channel-innermost, then pixel, then row; banks interleave rows/pixels.
//  FC mode: linear fill. Sits between the DDR read engine and the PE dbuf write ports.
// PARAMETERS
//  PE_NUM     32   number of PEs (multiple of BANK_NUM)
//  BANK_ROW   2    row interleave factor per PE group (power of 2)
//  BANK_PIX   2    pixel interleave factor per PE group (power of 2); BANK_NUM=BANK_ROW*BANK_PIX
//  BUF_DEPTH  256  dbuf entries; ADDR_W = bw(BUF_DEPTH)
//  CNT_W      8    width of channel/row/pixel counters and config fields
//  DDR_W      GLOBAL_PARAM::DDR_W   stream word width, written unmodified to dbuf
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous, active-high reset
//  start          in   1          begin transfer; sampled only in IDLE
//  done           out  1          1 = idle/complete
//  conf_mode      in   1          0 = CONV, 1 = FC; latched at start
//  conf_ch_num    in   CNT_W      CONV: channels-1; FC: words-1
//  conf_pix_num   in   CNT_W      pixels per row-1 (CONV)
//  conf_row_num   in   CNT_W      rows-1 (CONV)
//  conf_ch_stride in   ADDR_W     dbuf address step per channel (CONV)
//  conf_row_stride in  ADDR_W     dbuf address step per row group (CONV)
//  conf_mask      in   PE_NUM     PE write enable mask; latched at start
//  ddr_data       in   DDR_W      stream data
//  ddr_valid      in   1          stream valid
//  ddr_ready      out  1          stream ready
//  dbuf_wr_data   out  DDR_W      write data, broadcast to all PEs
//  dbuf_wr_addr   out  ADDR_W     write address
//  dbuf_wr_en     out  PE_NUM     per-PE write strobe
// BEHAVIOUR
//  - Reset: state IDLE, done=1, ddr_ready=0, dbuf_wr_en=0, wr_addr=0, wr_data=0, counters 0.
//  - FSM IDLE -> RUN on start (all conf_* latched, counters cleared, done falls next cycle);
//    RUN -> DRAIN when last word accepted; DRAIN -> IDLE after last write issued; done=1 in IDLE.
//  - start outside IDLE is ignored; conf_* changes after start have no effect.
//  - ddr_ready = (state==RUN), registered-free; accept = ddr_valid & ddr_ready.
//    ddr_valid outside RUN is not consumed.
//  - Latency: accepted word appears on dbuf_wr_* exactly 2 cycles later, both modes;
//    one write per accept, no gaps added.
//  - CONV counters: ch 0..conf_ch_num wraps -> pix++; pix 0..conf_pix_num wraps -> row++;
//    last = all three at max.
//    bank = (row % BANK_ROW)*BANK_PIX + (pix % BANK_PIX);
//    addr = ch*conf_ch_stride + (row/BANK_ROW)*conf_row_stride + pix/BANK_PIX,
//    kept by incremental adders (no multipliers), truncated mod 2^ADDR_W.
//    wr_en = replicate(onehot(bank), PE_NUM/BANK_NUM) & conf_mask.
//  - FC: addr = accept count (0..conf_ch_num); wr_en = conf_mask; last at count==conf_ch_num.
//  - conf values 0 are legal (single channel/pixel/row/word). conf_mask=0 runs normally
//    with no strobes.
//  - done rises the cycle after the final dbuf_wr_en pulse.
//  - rst mid-transfer: next cycle IDLE, wr_en=0, in-flight words discarded.
// STRUCTURE
//  - Package GLOBAL_PARAM: DDR_W, bw(); add typedef enum {DBUF_CONV, DBUF_FC} dbuf_mode_e
//    and state enum.
//  - Sub-module ddr2dbuf_addr_gen: ch/pix/row counters, incremental address, bank index,
//    last flag.
//  - Top: FSM, handshake, 2-stage data/address/enable pipeline.
// TESTING
//  1 FC, conf_ch_num=7, mask=32'h0000_00FF, valid held 1 -> 8 writes, addr 0..7,
//    wr_en=8'hFF each, done after last.
//  2 CONV ch=1,pix=3,row=1, strides 4/2 -> 16 writes; word k -> bank per formula,
//    addr = ch*4+pix/2; done 1 cycle after last.
//  3 CONV with random valid gaps and start pulsed in RUN -> identical write sequence to
//    gapless run, start ignored.
//  4 All conf 0 -> exactly one write to addr 0, bank 0; ready high one cycle.
//  5 rst asserted after 5 of 16 accepts -> next cycle wr_en=0, done=1, ready=0;
//    new start then completes correctly.
//  6 ch_stride*ch exceeds BUF_DEPTH -> address wraps mod 2^ADDR_W, no X, no stall.

Source files
------------

// File: rtl/ddr2dbuf_stream_pkg.sv
// Shared parameters and types for the DDR-to-dbuf stream loader.
//   DDR_W        : width of one DDR stream word
//   bw()         : address width needed to index n entries (minimum 1)
//   dbuf_mode_e  : CONV (channel/pixel/row walk) or FC (linear fill)
//   dbuf_state_e : loader control states
package GLOBAL_PARAM;

  localparam int unsigned DDR_W = 64;

  function automatic int unsigned bw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    DBUF_CONV = 1'b0,
    DBUF_FC   = 1'b1
  } dbuf_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dbuf_state_e;

endpackage

// File: rtl/ddr2dbuf_stream_addr_gen.sv
// Channel/pixel/row walker for the dbuf loader.
// Produces the dbuf address and bank index for the word about to be accepted,
// plus a flag marking the final word of the transfer.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : restart the walk from ch=pix=row=0, address 0
//   step          : advance to the next word (one per accepted stream word)
//   mode          : CONV walk or FC linear count
//   ch_num, pix_num, row_num : inclusive maxima of the three counters
//   ch_stride, row_stride    : address steps per channel / per row group
//   addr          : address of the current word
//   bank          : bank of the current word (CONV)
//   last          : current word is the final one
module ddr2dbuf_addr_gen
  import GLOBAL_PARAM::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned BANK_ROW = 2,
  parameter int unsigned BANK_PIX = 2,
  parameter int unsigned BANK_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  dbuf_mode_e        mode,
  input  logic [CNT_W-1:0]  ch_num,
  input  logic [CNT_W-1:0]  pix_num,
  input  logic [CNT_W-1:0]  row_num,
  input  logic [ADDR_W-1:0] ch_stride,
  input  logic [ADDR_W-1:0] row_stride,
  output logic [ADDR_W-1:0] addr,
  output logic [BANK_W-1:0] bank,
  output logic              last
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [CNT_W-1:0]  ch, pix, row;
  // row_base = (row/BANK_ROW)*row_stride, pix_base = row_base + pix/BANK_PIX;
  // addr then accumulates ch*ch_stride on top of pix_base.
  logic [ADDR_W-1:0] row_base, pix_base, addr_q;
  logic [ADDR_W-1:0] row_base_inc;
  logic              pix_grp_step, row_grp_step;

  always_comb begin
    pix_grp_step = ((32'(pix) + 32'd1) % BANK_PIX) == 32'd0;
    row_grp_step = ((32'(row) + 32'd1) % BANK_ROW) == 32'd0;
    row_base_inc = row_base + row_stride;
    addr         = addr_q;
    bank         = BANK_W'((32'(row) % BANK_ROW) * BANK_PIX + (32'(pix) % BANK_PIX));
    last         = (ch == ch_num) &&
                   ((mode == DBUF_FC) || ((pix == pix_num) && (row == row_num)));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ch       <= '0;
      pix      <= '0;
      row      <= '0;
      row_base <= '0;
      pix_base <= '0;
      addr_q   <= '0;
    end else if (step) begin
      if (mode == DBUF_FC) begin
        ch     <= ch + CNT_ONE;
        addr_q <= addr_q + ADDR_ONE;
      end else if (ch != ch_num) begin
        ch     <= ch + CNT_ONE;
        addr_q <= addr_q + ch_stride;
      end else begin
        ch <= '0;
        if (pix != pix_num) begin
          pix <= pix + CNT_ONE;
          if (pix_grp_step) begin
            pix_base <= pix_base + ADDR_ONE;
            addr_q   <= pix_base + ADDR_ONE;
          end else begin
            addr_q   <= pix_base;
          end
        end else begin
          pix <= '0;
          if (row != row_num) begin
            row <= row + CNT_ONE;
            if (row_grp_step) begin
              row_base <= row_base_inc;
              pix_base <= row_base_inc;
              addr_q   <= row_base_inc;
            end else begin
              pix_base <= row_base;
              addr_q   <= row_base;
            end
          end else begin
            row      <= '0;
            row_base <= '0;
            pix_base <= '0;
            addr_q   <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ddr2dbuf_stream.sv
// DDR-to-data-buffer loader with valid/ready backpressure.
// Accepts one DDR word per handshake and emits it, two cycles later, as a
// broadcast write with per-PE strobes (banked in CONV mode, masked in FC mode).
//   clk, rst          : clock, synchronous active-high reset
//   start / done      : launch a transfer from idle / idle-or-complete flag
//   conf_*            : transfer configuration, latched at start
//   ddr_data/valid/ready : input stream handshake
//   dbuf_wr_data/addr/en : dbuf write port (data broadcast, per-PE strobe)
module ddr2dbuf_stream
  import GLOBAL_PARAM::*;
#(
  parameter int unsigned PE_NUM    = 32,
  parameter int unsigned BANK_ROW  = 2,
  parameter int unsigned BANK_PIX  = 2,
  parameter int unsigned BUF_DEPTH = 256,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DDR_W     = GLOBAL_PARAM::DDR_W,
  localparam int unsigned ADDR_W   = bw(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic              conf_mode,
  input  logic [CNT_W-1:0]  conf_ch_num,
  input  logic [CNT_W-1:0]  conf_pix_num,
  input  logic [CNT_W-1:0]  conf_row_num,
  input  logic [ADDR_W-1:0] conf_ch_stride,
  input  logic [ADDR_W-1:0] conf_row_stride,
  input  logic [PE_NUM-1:0] conf_mask,
  input  logic [DDR_W-1:0]  ddr_data,
  input  logic              ddr_valid,
  output logic              ddr_ready,
  output logic [DDR_W-1:0]  dbuf_wr_data,
  output logic [ADDR_W-1:0] dbuf_wr_addr,
  output logic [PE_NUM-1:0] dbuf_wr_en
);

  localparam int unsigned BANK_NUM = BANK_ROW * BANK_PIX;
  localparam int unsigned BANK_W   = bw(BANK_NUM);

  dbuf_state_e       state, state_nx;
  logic              load, accept;

  dbuf_mode_e        mode_q;
  logic [CNT_W-1:0]  ch_num_q, pix_num_q, row_num_q;
  logic [ADDR_W-1:0] ch_stride_q, row_stride_q;
  logic [PE_NUM-1:0] mask_q;

  logic [ADDR_W-1:0] ag_addr;
  logic [BANK_W-1:0] ag_bank;
  logic              ag_last;

  logic [PE_NUM-1:0] strobe;

  logic              s1_valid;
  logic [DDR_W-1:0]  s1_data;
  logic [ADDR_W-1:0] s1_addr;
  logic [PE_NUM-1:0] s1_en;

  // ---------------- control ----------------
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    ddr_ready = (state == ST_RUN);
    done      = (state == ST_IDLE);
    accept    = ddr_valid && (state == ST_RUN);
    case (state)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && ag_last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Once stage 1 is empty the final word is on the outputs this cycle.
        if (!s1_valid) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= DBUF_CONV;
      ch_num_q     <= '0;
      pix_num_q    <= '0;
      row_num_q    <= '0;
      ch_stride_q  <= '0;
      row_stride_q <= '0;
      mask_q       <= '0;
    end else if (load) begin
      mode_q       <= conf_mode ? DBUF_FC : DBUF_CONV;
      ch_num_q     <= conf_ch_num;
      pix_num_q    <= conf_pix_num;
      row_num_q    <= conf_row_num;
      ch_stride_q  <= conf_ch_stride;
      row_stride_q <= conf_row_stride;
      mask_q       <= conf_mask;
    end
  end

  // ---------------- address walk ----------------
  ddr2dbuf_addr_gen #(
    .CNT_W    (CNT_W),
    .ADDR_W   (ADDR_W),
    .BANK_ROW (BANK_ROW),
    .BANK_PIX (BANK_PIX),
    .BANK_W   (BANK_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (load),
    .step       (accept),
    .mode       (mode_q),
    .ch_num     (ch_num_q),
    .pix_num    (pix_num_q),
    .row_num    (row_num_q),
    .ch_stride  (ch_stride_q),
    .row_stride (row_stride_q),
    .addr       (ag_addr),
    .bank       (ag_bank),
    .last       (ag_last)
  );

  // PE p belongs to bank p % BANK_NUM, i.e. the one-hot bank pattern repeated.
  always_comb begin
    strobe = '0;
    for (int unsigned p = 0; p < PE_NUM; p++) begin
      strobe[p] = (mode_q == DBUF_FC) || ((p % BANK_NUM) == 32'(ag_bank));
    end
    strobe = strobe & mask_q;
  end

  // ---------------- 2-stage write pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_addr  <= '0;
      s1_en    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= ddr_data;
        s1_addr <= ag_addr;
        s1_en   <= strobe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbuf_wr_data <= '0;
      dbuf_wr_addr <= '0;
      dbuf_wr_en   <= '0;
    end else begin
      dbuf_wr_en <= s1_valid ? s1_en : '0;
      if (s1_valid) begin
        dbuf_wr_data <= s1_data;
        dbuf_wr_addr <= s1_addr;
      end
    end
  end

endmodule

// File: tb/tb_ddr2dbuf_stream.sv
module tb_ddr2dbuf_stream;

  localparam int PE = 32;
  localparam int BR = 2;
  localparam int BP = 2;
  localparam int BN = BR * BP;
  localparam int AW = 8;
  localparam int CW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          done;
  logic          conf_mode;
  logic [CW-1:0] conf_ch_num, conf_pix_num, conf_row_num;
  logic [AW-1:0] conf_ch_stride, conf_row_stride;
  logic [PE-1:0] conf_mask;
  logic [DW-1:0] ddr_data;
  logic          ddr_valid;
  logic          ddr_ready;
  logic [DW-1:0] dbuf_wr_data;
  logic [AW-1:0] dbuf_wr_addr;
  logic [PE-1:0] dbuf_wr_en;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ddr2dbuf_stream #(
    .PE_NUM    (PE),
    .BANK_ROW  (BR),
    .BANK_PIX  (BP),
    .BUF_DEPTH (256),
    .CNT_W     (CW),
    .DDR_W     (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .done            (done),
    .conf_mode       (conf_mode),
    .conf_ch_num     (conf_ch_num),
    .conf_pix_num    (conf_pix_num),
    .conf_row_num    (conf_row_num),
    .conf_ch_stride  (conf_ch_stride),
    .conf_row_stride (conf_row_stride),
    .conf_mask       (conf_mask),
    .ddr_data        (ddr_data),
    .ddr_valid       (ddr_valid),
    .ddr_ready       (ddr_ready),
    .dbuf_wr_data    (dbuf_wr_data),
    .dbuf_wr_addr    (dbuf_wr_addr),
    .dbuf_wr_en      (dbuf_wr_en)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [PE-1:0] lane_pat(input int bank);
    logic [BN-1:0] oh;
    oh = BN'(1) << bank;
    return {(PE/BN){oh}};
  endfunction

  task automatic scramble_conf();
    conf_mode       = 1'($urandom);
    conf_ch_num     = CW'($urandom);
    conf_pix_num    = CW'($urandom);
    conf_row_num    = CW'($urandom);
    conf_ch_stride  = AW'($urandom);
    conf_row_stride = AW'($urandom);
    conf_mask       = PE'($urandom);
  endtask

  // Runs one transfer; expected writes come from the addressing formulas,
  // and each write must appear exactly two cycles after its accept.
  task automatic run_xfer(input string name, input logic mode,
                          input logic [CW-1:0] chn, input logic [CW-1:0] pxn,
                          input logic [CW-1:0] rwn, input logic [AW-1:0] cs,
                          input logic [AW-1:0] rs, input logic [PE-1:0] mask,
                          input int gap_pct, input bit pulse_start, input int abort_at);
    logic [AW-1:0] e_addr[$];
    logic [PE-1:0] e_en[$];
    int            n, acc, outc, cyc, h1k, h2k;
    bit            h1v, h2v, vld, done_exp;
    logic [DW-1:0] h1d, h2d, d;

    if (mode) begin
      for (int i = 0; i <= int'(chn); i++) begin
        e_addr.push_back(AW'(i));
        e_en.push_back(mask);
      end
    end else begin
      for (int r = 0; r <= int'(rwn); r++)
        for (int p = 0; p <= int'(pxn); p++)
          for (int c = 0; c <= int'(chn); c++) begin
            e_addr.push_back(AW'(c * int'(cs) + (r / BR) * int'(rs) + p / BP));
            e_en.push_back(lane_pat((r % BR) * BP + (p % BP)) & mask);
          end
    end
    n = e_addr.size();

    chk({name, "_idle_done"}, 64'(done), 64'd1);
    chk({name, "_idle_ready"}, 64'(ddr_ready), 64'd0);
    conf_mode = mode; conf_ch_num = chn; conf_pix_num = pxn; conf_row_num = rwn;
    conf_ch_stride = cs; conf_row_stride = rs; conf_mask = mask;
    ddr_valid = 1'($urandom);
    ddr_data  = {$urandom, $urandom};
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble_conf();

    acc = 0; outc = 0; cyc = 0;
    h1v = 0; h2v = 0; h1k = 0; h2k = 0; h1d = '0; h2d = '0;
    forever begin
      done_exp = (outc == n);
      chk({name, "_done"}, 64'(done), 64'(done_exp));
      chk({name, "_ready"}, 64'(ddr_ready), 64'(acc < n));
      if (h2v) begin
        chk({name, "_wr_en"}, 64'(dbuf_wr_en), 64'(e_en[h2k]));
        if (e_en[h2k] != '0) begin
          chk({name, "_wr_addr"}, 64'(dbuf_wr_addr), 64'(e_addr[h2k]));
          chk({name, "_wr_data"}, dbuf_wr_data, h2d);
        end
        outc++;
      end else begin
        chk({name, "_wr_en_idle"}, 64'(dbuf_wr_en), 64'd0);
      end
      if (done_exp) break;

      if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b1;
        ddr_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk({name, "_abort_en"}, 64'(dbuf_wr_en), 64'd0);
        chk({name, "_abort_done"}, 64'(done), 64'd1);
        chk({name, "_abort_ready"}, 64'(ddr_ready), 64'd0);
        return;
      end

      h2v = h1v; h2k = h1k; h2d = h1d;
      vld = ($urandom_range(99) >= gap_pct);
      d   = {$urandom, $urandom};
      ddr_valid = vld;
      ddr_data  = d;
      h1v = vld && (acc < n);
      h1k = acc;
      h1d = d;
      if (h1v) acc++;
      if (pulse_start) start = 1'($urandom);
      scramble_conf();

      tick();
      cyc++;
      if (cyc > 3000) begin
        tests++;
        failed++;
        $error("FAIL %s_timeout got=%0d writes exp=%0d", name, outc, n);
        break;
      end
    end
    start = 1'b0;
    ddr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ddr_valid = 1'b0; ddr_data = '0;
    conf_mode = 1'b0; conf_ch_num = '0; conf_pix_num = '0; conf_row_num = '0;
    conf_ch_stride = '0; conf_row_stride = '0; conf_mask = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_done", 64'(done), 64'd1);
    chk("reset_ready", 64'(ddr_ready), 64'd0);
    chk("reset_wr_en", 64'(dbuf_wr_en), 64'd0);
    chk("reset_wr_addr", 64'(dbuf_wr_addr), 64'd0);
    chk("reset_wr_data", dbuf_wr_data, 64'd0);

    run_xfer("fc8", 1'b1, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 32'h0000_00FF, 0, 1'b0, -1);
    run_xfer("conv16", 1'b0, 8'd1, 8'd3, 8'd1, 8'd4, 8'd2, '1, 0, 1'b0, -1);
    run_xfer("conv16_gaps", 1'b0, 8'd1, 8'd3, 8'd1, 8'd4, 8'd2, '1, 40, 1'b1, -1);
    run_xfer("all_zero", 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, '1, 0, 1'b0, -1);
    run_xfer("fc_zero", 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 32'h8000_0001, 0, 1'b0, -1);
    run_xfer("abort5", 1'b0, 8'd1, 8'd3, 8'd1, 8'd4, 8'd2, '1, 0, 1'b0, 5);
    run_xfer("after_abort", 1'b0, 8'd1, 8'd3, 8'd1, 8'd4, 8'd2, '1, 20, 1'b0, -1);
    run_xfer("wrap", 1'b0, 8'd3, 8'd2, 8'd4, 8'd200, 8'd37, 32'($urandom), 30, 1'b1, -1);
    run_xfer("mask0", 1'b0, 8'd2, 8'd1, 8'd2, 8'd3, 8'd5, '0, 25, 1'b0, -1);
    run_xfer("rand_conv", 1'b0, CW'($urandom_range(4)), CW'($urandom_range(5)),
             CW'($urandom_range(5)), AW'($urandom), AW'($urandom), 32'($urandom),
             int'($urandom_range(50)), 1'b1, -1);
    run_xfer("rand_fc", 1'b1, CW'($urandom_range(40)), 8'd0, 8'd0, 8'd0, 8'd0,
             32'($urandom), int'($urandom_range(50)), 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
